// File: rtl/timer_pkg.sv
// Shared types and constants for the irrigation countdown timer.
// Presets are written as 16-bit BCD MM:SS nibbles, e.g. 16'h0500 = 05:00.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } timer_state_t;

    localparam logic [3:0] SU_MAX = 4'd9;
    localparam logic [2:0] SD_MAX = 3'd5;
    localparam logic [3:0] MU_MAX = 4'd9;
    localparam logic [1:0] MD_MAX = 2'd3;

    localparam logic [15:0] PRESET_SPRINKLER_DEF = 16'h0500;
    localparam logic [15:0] PRESET_DRIP_DEF      = 16'h2000;

    typedef struct packed {
        logic [1:0] md;
        logic [3:0] mu;
        logic [2:0] sd;
        logic [3:0] su;
    } bcd_time_t;

    function automatic logic bcd_is_zero(input bcd_time_t t);
        return (t.md == 2'd0) && (t.mu == 4'd0) && (t.sd == 3'd0) && (t.su == 4'd0);
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of a down-counter: synchronous load, decrement on borrow_i,
// wraps 0 -> MAX and raises borrow_o so the next digit up decrements.
module bcd_down_digit #(
    parameter int unsigned    W   = 4,
    parameter logic [W-1:0]   MAX = W'(9)
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         borrow_i,
    output logic [W-1:0] value_o,
    output logic         borrow_o
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    // An out-of-range preset digit is clamped so the output stays legal BCD.
    always_comb begin
        value_d = value_q;
        if (load_i) begin
            value_d = (load_val_i > MAX) ? MAX : load_val_i;
        end else if (borrow_i) begin
            value_d = (value_q == '0) ? MAX : (value_q - W'(1));
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o  = value_q;
    assign borrow_o = borrow_i && !load_i && (value_q == '0);

endmodule

// File: rtl/irrigation_countdown_timer.sv
// MM:SS BCD countdown timer with sprinkler/drip presets, pause and expiry pulse.
//   state | meaning
//   IDLE  | after reset, count 00:00, waiting for load
//   RUN   | counting down one second per tick_1hz
//   HOLD  | paused, count frozen
//   DONE  | reached 00:00, held there until the next load
module irrigation_countdown_timer
    import timer_pkg::*;
#(
    parameter logic [15:0] PRESET_SPRINKLER = PRESET_SPRINKLER_DEF,
    parameter logic [15:0] PRESET_DRIP      = PRESET_DRIP_DEF
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       load,
    input  logic       tick_1hz,
    input  logic       pause,
    input  logic       splinker_mode_on,
    output logic [1:0] minutes_d,
    output logic [3:0] minutes_u,
    output logic [2:0] seconds_d,
    output logic [3:0] seconds_u,
    output logic       running,
    output logic       expired
);

    localparam bcd_time_t SPR_T = '{md: PRESET_SPRINKLER[13:12], mu: PRESET_SPRINKLER[11:8],
                                    sd: PRESET_SPRINKLER[6:4],   su: PRESET_SPRINKLER[3:0]};
    localparam bcd_time_t DRP_T = '{md: PRESET_DRIP[13:12], mu: PRESET_DRIP[11:8],
                                    sd: PRESET_DRIP[6:4],   su: PRESET_DRIP[3:0]};

    timer_state_t state_q;
    logic         running_q;
    logic         expired_q;

    bcd_time_t    cnt;
    bcd_time_t    preset_sel;
    logic         cnt_zero;
    logic         cnt_one;
    logic         dec_en;
    logic         borrow_su;
    logic         borrow_sd;
    logic         borrow_mu;
    logic         borrow_md;

    assign preset_sel = splinker_mode_on ? SPR_T : DRP_T;
    assign cnt_zero   = bcd_is_zero(cnt);
    assign cnt_one    = (cnt.md == 2'd0) && (cnt.mu == 4'd0) && (cnt.sd == 3'd0) && (cnt.su == 4'd1);

    // The zero guard keeps the chain from ever wrapping below 00:00.
    assign dec_en = (state_q == ST_RUN) && tick_1hz && !pause && !load && !cnt_zero;

    bcd_down_digit #(.W(4), .MAX(SU_MAX)) u_su (
        .clock(clock), .reset_n(reset_n), .load_i(load), .load_val_i(preset_sel.su),
        .borrow_i(dec_en), .value_o(cnt.su), .borrow_o(borrow_su)
    );

    bcd_down_digit #(.W(3), .MAX(SD_MAX)) u_sd (
        .clock(clock), .reset_n(reset_n), .load_i(load), .load_val_i(preset_sel.sd),
        .borrow_i(borrow_su), .value_o(cnt.sd), .borrow_o(borrow_sd)
    );

    bcd_down_digit #(.W(4), .MAX(MU_MAX)) u_mu (
        .clock(clock), .reset_n(reset_n), .load_i(load), .load_val_i(preset_sel.mu),
        .borrow_i(borrow_sd), .value_o(cnt.mu), .borrow_o(borrow_mu)
    );

    bcd_down_digit #(.W(2), .MAX(MD_MAX)) u_md (
        .clock(clock), .reset_n(reset_n), .load_i(load), .load_val_i(preset_sel.md),
        .borrow_i(borrow_mu), .value_o(cnt.md), .borrow_o(borrow_md)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            expired_q <= 1'b0;
            if (load) begin
                state_q   <= ST_RUN;
                running_q <= 1'b1;
            end else begin
                case (state_q)
                    ST_RUN: begin
                        if (pause) begin
                            state_q   <= ST_HOLD;
                            running_q <= 1'b0;
                        end else if (tick_1hz && (cnt_one || cnt_zero)) begin
                            state_q   <= ST_DONE;
                            running_q <= 1'b0;
                            expired_q <= 1'b1;
                        end
                    end
                    ST_HOLD: begin
                        if (!pause) begin
                            state_q   <= ST_RUN;
                            running_q <= 1'b1;
                        end
                    end
                    ST_IDLE, ST_DONE: begin
                        state_q <= state_q;
                    end
                    default: begin
                        state_q   <= ST_IDLE;
                        running_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // borrow out of the tens-of-minutes digit is unreachable thanks to the zero guard
    logic unused_borrow;
    assign unused_borrow = borrow_md;

    assign minutes_d = cnt.md;
    assign minutes_u = cnt.mu;
    assign seconds_d = cnt.sd;
    assign seconds_u = cnt.su;
    assign running   = running_q;
    assign expired   = expired_q;

endmodule

// File: tb/tb_irrigation_countdown_timer.sv
// Directed bench for irrigation_countdown_timer: single-cycle vector table
// followed by hand-written multi-cycle sequences.
module tb_irrigation_countdown_timer;

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic       load = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       pause = 1'b0;
    logic       splinker_mode_on = 1'b0;
    logic [1:0] minutes_d;
    logic [3:0] minutes_u;
    logic [2:0] seconds_d;
    logic [3:0] seconds_u;
    logic       running;
    logic       expired;

    int n_checks = 0;
    int n_fail   = 0;

    irrigation_countdown_timer dut (
        .clock(clock), .reset_n(reset_n), .load(load), .tick_1hz(tick_1hz),
        .pause(pause), .splinker_mode_on(splinker_mode_on),
        .minutes_d(minutes_d), .minutes_u(minutes_u),
        .seconds_d(seconds_d), .seconds_u(seconds_u),
        .running(running), .expired(expired)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        ld;
        logic        tk;
        logic        ps;
        logic        mode;
        logic [15:0] t;
        logic        run;
        logic        exp;
    } vec_t;

    vec_t vecs[14];

    function automatic logic [15:0] cur_time();
        return {2'b00, minutes_d, minutes_u, 1'b0, seconds_d, seconds_u};
    endfunction

    task automatic check(input string name, input logic [15:0] et, input logic er, input logic ee);
        n_checks++;
        if (cur_time() !== et || running !== er || expired !== ee) begin
            n_fail++;
            $display("FAIL %s: got %h running=%b expired=%b, required %h running=%b expired=%b",
                     name, cur_time(), running, expired, et, er, ee);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_load(input logic mode);
        load = 1'b1;
        splinker_mode_on = mode;
        tick_1hz = 1'b0;
        pause = 1'b0;
        step();
        load = 1'b0;
    endtask

    // Ticks every cycle; each cycle the digits must be legal BCD and no expiry seen.
    task automatic run_ticks(input int n);
        tick_1hz = 1'b1;
        for (int i = 0; i < n; i++) begin
            step();
            n_checks++;
            if (minutes_d > 2'd3 || minutes_u > 4'd9 || seconds_d > 3'd5 || seconds_u > 4'd9
                || expired !== 1'b0) begin
                n_fail++;
                $display("FAIL run_ticks[%0d]: got %h expired=%b, required legal BCD and expired=0",
                         i, cur_time(), expired);
            end
        end
        tick_1hz = 1'b0;
    endtask

    initial begin
        //              ld  tk  ps  mode time      run exp
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0500, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0500, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0459, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0458, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0457, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0457, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0457, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0457, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0457, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0456, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h2000, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h1959, 1'b1, 1'b0};

        #2 reset_n = 1'b0;
        #1 check("reset_state", 16'h0000, 1'b0, 1'b0);
        step();
        reset_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            load = vecs[i].ld;
            tick_1hz = vecs[i].tk;
            pause = vecs[i].ps;
            splinker_mode_on = vecs[i].mode;
            step();
            check($sformatf("vec%0d", i), vecs[i].t, vecs[i].run, vecs[i].exp);
        end
        load = 1'b0; tick_1hz = 1'b0; pause = 1'b0;

        // reset in the middle of a count at 12:34
        do_load(1'b0);
        check("drip_load", 16'h2000, 1'b1, 1'b0);
        run_ticks(446);
        check("at_12_34", 16'h1234, 1'b1, 1'b0);
        #2 reset_n = 1'b0;
        #1 check("async_reset_mid_run", 16'h0000, 1'b0, 1'b0);
        step();
        reset_n = 1'b1;
        tick_1hz = 1'b1;
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("idle_after_reset%0d", i), 16'h0000, 1'b0, 1'b0);
            pause = ~pause;
        end
        tick_1hz = 1'b0; pause = 1'b0;

        // minutes borrow chain
        do_load(1'b0);
        run_ticks(600);
        check("at_10_00", 16'h1000, 1'b1, 1'b0);
        run_ticks(1);
        check("borrow_09_59", 16'h0959, 1'b1, 1'b0);

        // seconds/minutes borrow and expiry
        do_load(1'b1);
        run_ticks(240);
        check("at_01_00", 16'h0100, 1'b1, 1'b0);
        run_ticks(1);
        check("borrow_00_59", 16'h0059, 1'b1, 1'b0);
        run_ticks(58);
        check("at_00_01", 16'h0001, 1'b1, 1'b0);
        tick_1hz = 1'b1;
        step();
        check("expire", 16'h0000, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            pause = i[0];
            step();
            check($sformatf("done_hold%0d", i), 16'h0000, 1'b0, 1'b0);
        end
        tick_1hz = 1'b0; pause = 1'b0;

        // pause across ticks, reload from DONE
        do_load(1'b1);
        check("reload_from_done", 16'h0500, 1'b1, 1'b0);
        run_ticks(105);
        check("at_03_15", 16'h0315, 1'b1, 1'b0);
        pause = 1'b1;
        tick_1hz = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("paused%0d", i), 16'h0315, 1'b0, 1'b0);
        end
        pause = 1'b0;
        tick_1hz = 1'b0;
        step();
        check("unpause", 16'h0315, 1'b1, 1'b0);
        tick_1hz = 1'b1;
        step();
        check("tick_after_unpause", 16'h0314, 1'b1, 1'b0);
        tick_1hz = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
